tl_cntr_param: RTL

Parametrised multi-approach traffic light controller. It is the successor to the two-road Ta/Tb controller. It serves N_DIR approaches in round-robin order and uses per-phase cycle timers: minimum green, maximum green, yellow and all-red. It adds a flashing maintenance mode. It sits between the road sensor inputs and the lamp drivers, with one 2-bit light code per approach.

---
 rtl/tl_pkg.sv | 17 +
 rtl/tl_rr_arbiter.sv | 39 +++
 rtl/tl_cntr_param.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared definitions for the parametrised traffic light controller:
// lamp codes driven per approach and the controller state encoding.
package tl_pkg;

    localparam logic [1:0] TL_GREEN  = 2'b00;
    localparam logic [1:0] TL_YELLOW = 2'b01;
    localparam logic [1:0] TL_RED    = 2'b10;
    localparam logic [1:0] TL_OFF    = 2'b11;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_FLASH  = 2'd3
    } tl_state_e;

endpackage

// File: rtl/tl_rr_arbiter.sv
// Round-robin search for the next waiting approach after the current phase.
// The current phase itself is never a candidate, so "found" doubles as the
// "some other approach is requesting" indication.
module tl_rr_arbiter
    import tl_pkg::*;
#(
    parameter int N_DIR = 2,
    parameter int PH_W  = 3
) (
    input  logic [N_DIR-1:0] traffic,
    input  logic [PH_W-1:0]  phase,
    output logic [PH_W-1:0]  next_idx,
    output logic             found
);

    function automatic int wrap_idx(input logic [PH_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_DIR) s = s - N_DIR;
        return s;
    endfunction

    logic [N_DIR-1:0] shifted;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        next_idx = phase;
        found    = 1'b0;
        shifted  = '0;
        for (int k = N_DIR - 1; k >= 1; k--) begin
            shifted = traffic >> wrap_idx(phase, k);
            if (shifted[0]) begin
                next_idx = PH_W'(wrap_idx(phase, k));
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_cntr_param.sv
// Multi-approach traffic light controller with round-robin service,
// min/max green, yellow and all-red clearance, and a flashing maintenance mode.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_GREEN  | approach "phase" green, all others red
// ST_YELLOW | approach "phase" yellow for YELLOW_T cycles
// ST_ALLRED | every approach red for ALLRED_T cycles
// ST_FLASH  | maintenance: approach 0 blinks yellow, others blink red
module tl_cntr_param
    import tl_pkg::*;
#(
    parameter int N_DIR     = 2,
    parameter int PH_W      = 3,
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 16,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int FLASH_T   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_DIR-1:0]     traffic,
    input  logic                 flash_en,
    output logic [2*N_DIR-1:0]   lights,
    output logic [PH_W-1:0]      phase,
    output logic                 in_flash
);

    localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_M1   = CNT_W'((ALLRED_T == 0) ? 0 : ALLRED_T - 1);
    localparam logic [CNT_W-1:0] FL_M1   = CNT_W'(FLASH_T - 1);

    tl_state_e        state, nxt_state;
    logic [CNT_W-1:0] timer, nxt_timer;
    logic [CNT_W-1:0] fl_cnt, nxt_fl_cnt;
    logic [PH_W-1:0]  next_phase, nxt_next_phase, nxt_phase;
    logic             from_flash, nxt_from_flash;
    logic             blink, nxt_blink;
    logic             clr_exit;
    logic             own_req;
    logic [PH_W-1:0]  arb_idx;
    logic             arb_found;

    tl_rr_arbiter #(
        .N_DIR (N_DIR),
        .PH_W  (PH_W)
    ) u_arb (
        .traffic  (traffic),
        .phase    (phase),
        .next_idx (arb_idx),
        .found    (arb_found)
    );

    assign own_req = |(traffic & (N_DIR'(1) << phase));

    function automatic logic [2*N_DIR-1:0] decode(input tl_state_e st,
                                                  input logic [PH_W-1:0] ph,
                                                  input logic bl);
        logic [2*N_DIR-1:0] v;
        logic [1:0]         c;
        v = '0;
        for (int i = 0; i < N_DIR; i++) begin
            c = TL_RED;
            case (st)
                ST_GREEN:  if (PH_W'(i) == ph) c = TL_GREEN;
                ST_YELLOW: if (PH_W'(i) == ph) c = TL_YELLOW;
                ST_FLASH:  c = bl ? TL_OFF : ((i == 0) ? TL_YELLOW : TL_RED);
                default:   c = TL_RED;
            endcase
            v[2*i +: 2] = c;
        end
        return v;
    endfunction

    // Next-state, phase hand-over, blink and timer computation.
    always_comb begin
        nxt_state      = state;
        nxt_phase      = phase;
        nxt_next_phase = next_phase;
        nxt_from_flash = from_flash;
        nxt_blink      = blink;
        nxt_fl_cnt     = fl_cnt;
        clr_exit       = 1'b0;

        case (state)
            ST_GREEN: begin
                if (timer >= GMIN_M1 &&
                    (flash_en || (arb_found && (!own_req || timer >= GMAX_M1)))) begin
                    nxt_state      = ST_YELLOW;
                    nxt_next_phase = arb_found ? arb_idx : phase;
                end
            end
            ST_YELLOW: begin
                if (timer >= YEL_M1) begin
                    if (ALLRED_T == 0) clr_exit = 1'b1;
                    else               nxt_state = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                if (timer >= AR_M1) clr_exit = 1'b1;
            end
            default: begin
                if (!flash_en) begin
                    if (ALLRED_T == 0) begin
                        nxt_state = ST_GREEN;
                        nxt_phase = '0;
                    end else begin
                        nxt_state      = ST_ALLRED;
                        nxt_from_flash = 1'b1;
                    end
                end else if (fl_cnt == FL_M1) begin
                    nxt_fl_cnt = '0;
                    nxt_blink  = ~blink;
                end else begin
                    nxt_fl_cnt = fl_cnt + 1'b1;
                end
            end
        endcase

        // End of a clearance interval: flash wins, then a return from flash
        // restarts at approach 0, otherwise hand green to the latched winner.
        if (clr_exit) begin
            if (flash_en) begin
                nxt_state  = ST_FLASH;
                nxt_blink  = 1'b0;
                nxt_fl_cnt = '0;
            end else if (from_flash) begin
                nxt_state      = ST_GREEN;
                nxt_phase      = '0;
                nxt_from_flash = 1'b0;
            end else begin
                nxt_state = ST_GREEN;
                nxt_phase = next_phase;
            end
        end

        if (nxt_state != state)  nxt_timer = '0;
        else if (timer == '1)    nxt_timer = timer;
        else                     nxt_timer = timer + 1'b1;
    end

    // State registers and registered lamp/flag outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_GREEN;
            phase      <= '0;
            timer      <= '0;
            next_phase <= '0;
            from_flash <= 1'b0;
            blink      <= 1'b0;
            fl_cnt     <= '0;
            in_flash   <= 1'b0;
            lights     <= decode(ST_GREEN, PH_W'(0), 1'b0);
        end else begin
            state      <= nxt_state;
            phase      <= nxt_phase;
            timer      <= nxt_timer;
            next_phase <= nxt_next_phase;
            from_flash <= nxt_from_flash;
            blink      <= nxt_blink;
            fl_cnt     <= nxt_fl_cnt;
            in_flash   <= (nxt_state == ST_FLASH);
            lights     <= decode(nxt_state, nxt_phase, nxt_blink);
        end
    end

endmodule
